// File: rtl/led_bank_arbiter.sv
// led_bank_arbiter: arbitrates an active-low LED bank among a heartbeat
// pattern, a host override pattern and blinked error codes.
// Priority: error > host > heartbeat.
// Optional build macro: LED_ERR_LATCH_EN (sticky fault; error bursts repeat
// until reset and the host is locked out).
module led_bank_arbiter #(
    parameter int NUM_LED    = 8,
    parameter int PRESCALE   = 65536,
    parameter int HOLD_TICKS = 32,
    parameter int GAP_TICKS  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_LED-1:0] hb_pattern_i,
    input  logic               host_req_i,
    input  logic [NUM_LED-1:0] host_pattern_i,
    output logic               host_ack_o,
    input  logic               err_valid_i,
    input  logic [3:0]         err_code_i,
    output logic               err_ready_o,
    output logic [NUM_LED-1:0] led_o,
    output logic [1:0]         owner_o
);

    localparam int PW   = $clog2(PRESCALE);
    localparam int TMAX = (HOLD_TICKS > GAP_TICKS) ? HOLD_TICKS : GAP_TICKS;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        ST_HB,
        ST_HOST,
        ST_ERR_ON,
        ST_ERR_OFF,
        ST_ERR_GAP
    } state_t;

    state_t             state_q, state_d;
    logic [PW-1:0]      presc_q;
    logic [TW-1:0]      cnt_q, cnt_d;
    logic [3:0]         blink_q, blink_d;
    logic [NUM_LED-1:0] hpat_q, hpat_d;
    logic [NUM_LED-1:0] led_q;
    logic [1:0]         owner_q;
    logic [NUM_LED-1:0] disp;
    logic               tick;
    logic               err_acc;
    logic               host_latch;
`ifdef LED_ERR_LATCH_EN
    logic [3:0]         code_q, code_d;
`endif

    assign tick        = (presc_q == PW'(PRESCALE - 1));
    // The error port is only open while the bank is not already showing an error.
    assign err_ready_o = ((state_q == ST_HB) || (state_q == ST_HOST)) && !rst;
    assign err_acc     = err_valid_i && err_ready_o;
    assign host_ack_o  = host_latch && !rst;
    assign led_o       = led_q;
    assign owner_o     = owner_q;

    // Next-state logic: arbitration, hold/gap tick counting and blink counting.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        blink_d    = blink_q;
        hpat_d     = hpat_q;
        host_latch = 1'b0;
`ifdef LED_ERR_LATCH_EN
        code_d     = code_q;
`endif
        if (tick) begin
            cnt_d = cnt_q + TW'(1);
        end
        case (state_q)
            ST_HB: begin
                // An error handshake (even code 0) wins the cycle over the host.
                if (err_acc) begin
                    if (err_code_i != 4'd0) begin
                        state_d = ST_ERR_ON;
                        blink_d = err_code_i;
`ifdef LED_ERR_LATCH_EN
                        code_d  = err_code_i;
`endif
                    end
                end else if (host_req_i) begin
                    host_latch = 1'b1;
                    hpat_d     = host_pattern_i;
                    state_d    = ST_HOST;
                end
            end
            ST_HOST: begin
                if (err_acc && (err_code_i != 4'd0)) begin
                    state_d = ST_ERR_ON;
                    blink_d = err_code_i;
`ifdef LED_ERR_LATCH_EN
                    code_d  = err_code_i;
`endif
                end else if (tick && (cnt_q == TW'(HOLD_TICKS - 1))) begin
                    if (host_req_i) begin
                        // Re-latch and restart the hold without leaving HOST.
                        host_latch = 1'b1;
                        hpat_d     = host_pattern_i;
                        cnt_d      = '0;
                    end else begin
                        state_d = ST_HB;
                    end
                end
            end
            ST_ERR_ON: begin
                if (tick) begin
                    state_d = ST_ERR_OFF;
                end
            end
            ST_ERR_OFF: begin
                if (tick) begin
                    blink_d = blink_q - 4'd1;
                    state_d = (blink_q == 4'd1) ? ST_ERR_GAP : ST_ERR_ON;
                end
            end
            ST_ERR_GAP: begin
                if (tick && (cnt_q == TW'(GAP_TICKS - 1))) begin
`ifdef LED_ERR_LATCH_EN
                    state_d = ST_ERR_ON;
                    blink_d = code_q;
`else
                    state_d = ST_HB;
`endif
                end
            end
            default: begin
                state_d = ST_HB;
            end
        endcase
        // Every phase starts with a fresh tick count.
        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    // Pattern selected for display by the current state.
    always_comb begin
        disp = '0;
        case (state_q)
            ST_HB:      disp = hb_pattern_i;
            ST_HOST:    disp = hpat_q;
            ST_ERR_ON:  disp = '1;
            default:    disp = '0;
        endcase
    end

    // Control registers: state, prescaler, tick counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_HB;
            presc_q <= '0;
            cnt_q   <= '0;
            led_q   <= '1;
            owner_q <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            // Prescaler restarts on every state change so phases are whole ticks.
            if (tick || (state_d != state_q)) begin
                presc_q <= '0;
            end else begin
                presc_q <= presc_q + PW'(1);
            end
            led_q <= ~disp;
            case (state_q)
                ST_HB:   owner_q <= 2'd0;
                ST_HOST: owner_q <= 2'd1;
                default: owner_q <= 2'd2;
            endcase
        end
    end

    // Data registers: latched host pattern and blink count (no reset needed).
    always_ff @(posedge clk) begin
        hpat_q  <= hpat_d;
        blink_q <= blink_d;
`ifdef LED_ERR_LATCH_EN
        code_q  <= code_d;
`endif
    end

endmodule
